dma_desc_fetcher: RTL and testbench

Upstream feeder for the L1 DMA descriptor FIFO. It walks a linked list of descriptors in memory, starting from a head pointer written by software. Each descriptor is pushed onto the FIFO write side as {src, dst, len, last}, so the CPU no longer programs every transfer through the DMA CSRs. It sits beside the CSR block, on the same FIFO write port, and arbitration with the CSR path is handled outside this block.

---
 rtl/dma_desc_fetcher.sv | 214 +++++++++++++++++++++
 tb/tb_dma_desc_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_fetcher.sv
// dma_desc_fetcher
//   Walks a linked list of 128-bit descriptors in memory, starting at a
//   software-supplied head pointer. Each descriptor is pushed to the DMA
//   descriptor FIFO as {src, dst, len, last}.
//
// Parameters
//   ADDR_WIDTH  byte-address width of descriptor pointers
//   MAX_CHAIN   maximum descriptors per chain (loop guard)
//   DESC_ALIGN  required byte alignment of head/next pointers (power of two)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start_i, head_addr_i      one-cycle start pulse and first descriptor address
//   mem_req_o, mem_addr_o     descriptor read request / address (held until gnt)
//   mem_gnt_i                 request accepted
//   mem_rvalid_i, mem_rdata_i read data: [31:0] src, [63:32] dst,
//                             [95:64] len, [127:96] next
//   fifo_write_o, fifo_data_o push strobe / {src, dst, len, last}, last at bit 0
//   fifo_full_i               FIFO full, stalls the push
//   busy_o                    chain in progress
//   done_o                    pulse with the push of the last descriptor
//   error_o, err_addr_o       sticky error and offending descriptor address
//
// Optional feature (macro DMA_DESC_FETCH_ABORT_EN)
//   Adds input abort_i. Abort in any active state returns to IDLE without
//   pushing and flags error_o with err_addr_o = current descriptor address.
//   An already granted read is drained (rvalid awaited and discarded) first.
module dma_desc_fetcher #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_CHAIN  = 256,
  parameter int unsigned DESC_ALIGN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] head_addr_i,
`ifdef DMA_DESC_FETCH_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [127:0]          mem_rdata_i,
  output logic                  fifo_write_o,
  output logic [96:0]           fifo_data_o,
  input  logic                  fifo_full_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o
);

  localparam int unsigned CW = (MAX_CHAIN > 1) ? $clog2(MAX_CHAIN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CHECK, S_PUSH, S_ERR
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [CW-1:0]         r_count;
  logic [127:0]          r_desc;
  logic                  r_error;

  logic [31:0]           w_src, w_dst, w_len, w_nxt;
  logic                  w_last;
  logic                  w_head_bad, w_next_bad, w_limit;
  logic                  w_accept, w_capture, w_advance, w_set_err;
  logic [ADDR_WIDTH-1:0] w_err_addr;

`ifdef DMA_DESC_FETCH_ABORT_EN
  logic                  r_abort_pend;
  logic                  w_pend_set;
`endif

  assign w_src  = r_desc[31:0];
  assign w_dst  = r_desc[63:32];
  assign w_len  = r_desc[95:64];
  assign w_nxt  = r_desc[127:96];
  assign w_last = (w_nxt == '0);

  assign w_head_bad = (head_addr_i & ADDR_WIDTH'(DESC_ALIGN - 1)) != '0;
  assign w_next_bad = !w_last && ((w_nxt & 32'(DESC_ALIGN - 1)) != '0);
  // Loop guard: the last permitted descriptor must terminate the chain.
  assign w_limit    = !w_last && (r_count == CW'(MAX_CHAIN - 1));

  always_comb begin
    w_next       = r_state;
    mem_req_o    = 1'b0;
    fifo_write_o = 1'b0;
    done_o       = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_set_err    = 1'b0;
    w_err_addr   = r_cur_addr;
`ifdef DMA_DESC_FETCH_ABORT_EN
    w_pend_set   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_head_bad) begin
            w_next     = S_ERR;
            w_set_err  = 1'b1;
            w_err_addr = head_addr_i;
          end else begin
            w_next   = S_REQ;
            w_accept = 1'b1;
          end
        end
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_capture = 1'b1;
          w_next    = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((w_len == '0) || w_next_bad || w_limit) begin
          w_next    = S_ERR;
          w_set_err = 1'b1;
        end else begin
          w_next = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!fifo_full_i) begin
          fifo_write_o = 1'b1;
          if (w_last) begin
            done_o = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_advance = 1'b1;
            w_next    = S_REQ;
          end
        end
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
`ifdef DMA_DESC_FETCH_ABORT_EN
    // Abort overrides the normal flow. A read that is granted (or already
    // outstanding) must still see its rvalid, so the FSM parks in WAIT and
    // drops the returning data.
    if (r_state == S_WAIT && r_abort_pend) begin
      w_capture = 1'b0;
      w_next    = mem_rvalid_i ? S_IDLE : S_WAIT;
    end else if (abort_i && r_state != S_IDLE && r_state != S_ERR) begin
      fifo_write_o = 1'b0;
      done_o       = 1'b0;
      w_advance    = 1'b0;
      w_capture    = 1'b0;
      w_set_err    = 1'b1;
      w_err_addr   = r_cur_addr;
      if ((r_state == S_REQ && mem_gnt_i) || (r_state == S_WAIT && !mem_rvalid_i)) begin
        w_next     = S_WAIT;
        w_pend_set = 1'b1;
      end else begin
        w_next = S_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_err_addr <= '0;
      r_count    <= '0;
      r_desc     <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cur_addr <= head_addr_i;
        r_count    <= '0;
        r_error    <= 1'b0;
        r_err_addr <= '0;
      end
      if (w_capture) r_desc <= mem_rdata_i;
      if (w_advance) begin
        r_cur_addr <= ADDR_WIDTH'(w_nxt);
        r_count    <= r_count + 1'b1;
      end
      if (w_set_err) begin
        r_error    <= 1'b1;
        r_err_addr <= w_err_addr;
      end
    end
  end

`ifdef DMA_DESC_FETCH_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst)                  r_abort_pend <= 1'b0;
    else if (w_pend_set)      r_abort_pend <= 1'b1;
    else if (w_next != S_WAIT) r_abort_pend <= 1'b0;
  end
`endif

  assign mem_addr_o  = mem_req_o ? r_cur_addr : '0;
  assign fifo_data_o = (r_state == S_PUSH) ? {w_src, w_dst, w_len, w_last} : '0;
  assign busy_o      = (r_state != S_IDLE);
  assign error_o     = r_error;
  assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_dma_desc_fetcher.sv
// tb_dma_desc_fetcher
//   Self-checking bench for dma_desc_fetcher (MAX_CHAIN = 4). A memory
//   responder serves descriptor reads, a monitor records pushes/requests,
//   and a list-walking reference model predicts each chain's outcome.
module tb_dma_desc_fetcher;
  localparam int unsigned AW = 32;
  localparam int unsigned MC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [AW-1:0] head_addr_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [127:0]  mem_rdata_i;
  logic          fifo_write_o;
  logic [96:0]   fifo_data_o;
  logic          fifo_full_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [AW-1:0] err_addr_o;
`ifdef DMA_DESC_FETCH_ABORT_EN
  logic          abort_i = 1'b0;
`endif

  dma_desc_fetcher #(.ADDR_WIDTH(AW), .MAX_CHAIN(MC), .DESC_ALIGN(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .head_addr_i(head_addr_i),
`ifdef DMA_DESC_FETCH_ABORT_EN
    .abort_i(abort_i),
`endif
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .fifo_write_o(fifo_write_o), .fifo_data_o(fifo_data_o), .fifo_full_i(fifo_full_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // ---------------- memory ----------------
  logic [127:0] mem [logic [31:0]];

  function automatic logic [127:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  function automatic logic [127:0] mk(input logic [31:0] s, input logic [31:0] d,
                                      input logic [31:0] l, input logic [31:0] n);
    return {n, l, d, s};
  endfunction

  int           gnt_delay = 0, rv_delay = 0, gnt_wait = 0, rv_cnt = 0;
  bit           rand_lat = 0, rand_full = 0, rv_pend = 0;
  logic [127:0] rv_data;

  initial begin
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 0; mem_rdata_i = '0; mem_gnt_i = 0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid_i = 1; mem_rdata_i = rv_data; rv_pend = 0;
        end else rv_cnt--;
      end
      if (mem_req_o) begin
        if (gnt_wait > 0) gnt_wait--;
        else begin
          mem_gnt_i = 1; rv_pend = 1; rv_data = rd(mem_addr_o);
          rv_cnt   = rand_lat ? int'($urandom_range(0, 2)) : rv_delay;
          gnt_wait = rand_lat ? int'($urandom_range(0, 2)) : gnt_delay;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_full) fifo_full_i = ($urandom_range(0, 1) == 1);
  end

  // ---------------- monitor ----------------
  logic [96:0] got_push[$];
  int          got_pcyc[$];
  logic [31:0] got_req[$];
  int          n_done = 0, done_cyc = -1, busy_fall_cyc = -1;
  logic        p_req = 0, p_gnt = 0, p_busy = 0, p_rst = 1;
  logic [31:0] p_addr = '0;

  initial forever begin
    @(negedge clk); #2;
    if (fifo_write_o) begin got_push.push_back(fifo_data_o); got_pcyc.push_back(cyc); end
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (fifo_full_i && busy_o) check("no_push_while_full", fifo_write_o, 0);
    if (mem_req_o && mem_gnt_i) got_req.push_back(mem_addr_o);
    if (p_req && !p_gnt && !p_rst && !rst) begin
      check("req_held_until_gnt", mem_req_o, 1);
      check("addr_held_until_gnt", mem_addr_o, p_addr);
    end
    if (p_busy && !busy_o) busy_fall_cyc = cyc;
    p_req = mem_req_o; p_gnt = mem_gnt_i; p_addr = mem_addr_o; p_busy = busy_o; p_rst = rst;
  end

  // ---------------- reference model ----------------
  // Walks the list by the descriptor rules directly on the memory image.
  logic [96:0] exp_push[$];
  logic [31:0] exp_req[$];
  bit          exp_err, exp_done;
  logic [31:0] exp_eaddr;

  function automatic void model(input logic [31:0] head);
    logic [31:0] a, nx;
    logic [127:0] d;
    exp_push.delete(); exp_req.delete();
    exp_err = 0; exp_done = 0; exp_eaddr = '0;
    if (head % 16 != 0) begin exp_err = 1; exp_eaddr = head; return; end
    a = head;
    for (int n = 0; n < int'(MC); n++) begin
      exp_req.push_back(a);
      d  = rd(a);
      nx = d[127:96];
      if (d[95:64] == 0 || (nx != 0 && nx % 16 != 0) || (nx != 0 && n == int'(MC) - 1)) begin
        exp_err = 1; exp_eaddr = a; return;
      end
      exp_push.push_back({d[31:0], d[63:32], d[95:64], nx == 0});
      if (nx == 0) begin exp_done = 1; return; end
      a = nx;
    end
  endfunction

  task automatic start_run(input logic [31:0] head, output int st);
    model(head);
    got_push.delete(); got_pcyc.delete(); got_req.delete();
    n_done = 0; done_cyc = -1; busy_fall_cyc = -1;
    @(negedge clk); start_i = 1; head_addr_i = head;
    #3 st = cyc;
    @(negedge clk); start_i = 0; head_addr_i = $urandom;
    #3;
    check("error_after_start", error_o, head % 16 != 0);
    if (head % 16 != 0) check("err_addr_misaligned_head", err_addr_o, head);
  endtask

  task automatic finish_run(input string tag);
    int k = 0;
    while (busy_o && k < 3000) begin @(negedge clk); #3; k++; end
    if (busy_o) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout: busy_o still 1 after %0d cycles, required 0", tag, k);
    end
    check({tag, " push_count"}, got_push.size(), exp_push.size());
    for (int i = 0; i < got_push.size() && i < exp_push.size(); i++)
      check({tag, " push_data"}, got_push[i], exp_push[i]);
    check({tag, " req_count"}, got_req.size(), exp_req.size());
    for (int i = 0; i < got_req.size() && i < exp_req.size(); i++)
      check({tag, " req_addr"}, got_req[i], exp_req[i]);
    check({tag, " done_count"}, n_done, exp_done);
    check({tag, " error_o"}, error_o, exp_err);
    check({tag, " err_addr_o"}, err_addr_o, exp_eaddr);
    if (exp_done && got_pcyc.size() > 0)
      check({tag, " done_with_last_push"}, done_cyc, got_pcyc[got_pcyc.size()-1]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string              name;
    logic [31:0]        head;
    logic [3:0][127:0]  d;
    int                 np;
    bit                 err;
    logic [31:0]        eaddr;
    bit                 done;
  } vec_t;

  vec_t tv[8];

  task automatic load_table(input int i);
    mem.delete();
    for (int j = 0; j < 4; j++) mem[32'h1000 + 32'(16 * j)] = tv[i].d[j];
  endtask

  int st, rel;

  initial begin
    tv[0] = '{"single", 32'h1000, {128'h0, 128'h0, 128'h0, mk(32'h2000, 32'h3000, 32'h40, 0)}, 1, 0, 0, 1};
    tv[1] = '{"chain3", 32'h1000, {128'h0, mk(32'h2200, 32'h3200, 32'h30, 0),
              mk(32'h2100, 32'h3100, 32'h20, 32'h1020), mk(32'h2000, 32'h3000, 32'h10, 32'h1010)}, 3, 0, 0, 1};
    tv[2] = '{"len0", 32'h1000, {128'h0, 128'h0, mk(32'h2100, 32'h3100, 0, 32'h1020),
              mk(32'h2000, 32'h3000, 32'h10, 32'h1010)}, 1, 1, 32'h1010, 0};
    tv[3] = '{"head_misalign", 32'h1004, {128'h0, 128'h0, 128'h0, mk(32'h2000, 32'h3000, 32'h40, 0)}, 0, 1, 32'h1004, 0};
    tv[4] = '{"next_misalign", 32'h1000, {128'h0, 128'h0, mk(32'h2100, 32'h3100, 32'h8, 32'h1018),
              mk(32'h2000, 32'h3000, 32'h10, 32'h1010)}, 1, 1, 32'h1010, 0};
    tv[5] = '{"loop_guard", 32'h1000, {128'h0, 128'h0, 128'h0, mk(32'h2000, 32'h3000, 32'h40, 32'h1000)}, 3, 1, 32'h1000, 0};
    tv[6] = '{"max_chain", 32'h1000, {mk(32'h2300, 32'h3300, 32'h4, 0), mk(32'h2200, 32'h3200, 32'h3, 32'h1030),
              mk(32'h2100, 32'h3100, 32'h2, 32'h1020), mk(32'h2000, 32'h3000, 32'h1, 32'h1010)}, 4, 0, 0, 1};
    tv[7] = '{"len0_first", 32'h1000, {128'h0, 128'h0, 128'h0, mk(32'h2000, 32'h3000, 0, 32'h1018)}, 0, 1, 32'h1000, 0};

    rst = 1; start_i = 0; head_addr_i = '0; fifo_full_i = 0;
    repeat (3) @(negedge clk);
    #3;
    check("reset busy_o", busy_o, 0);
    check("reset mem_req_o", mem_req_o, 0);
    check("reset fifo_write_o", fifo_write_o, 0);
    check("reset fifo_data_o", fifo_data_o, 0);
    check("reset done_o", done_o, 0);
    check("reset error_o", error_o, 0);
    check("reset err_addr_o", err_addr_o, 0);
    @(negedge clk); rst = 0;

    // Table: immediate gnt/rvalid, FIFO never full.
    for (int i = 0; i < 8; i++) begin
      load_table(i);
      start_run(tv[i].head, st);
      finish_run(tv[i].name);
      check({tv[i].name, " tbl_pushes"}, got_push.size(), tv[i].np);
      check({tv[i].name, " tbl_error"}, error_o, tv[i].err);
      check({tv[i].name, " tbl_err_addr"}, err_addr_o, tv[i].eaddr);
      check({tv[i].name, " tbl_done"}, n_done, tv[i].done);
      if (got_pcyc.size() > 0) check({tv[i].name, " first_push_latency"}, got_pcyc[0] - st, 4);
      if (tv[i].done && got_pcyc.size() > 0)
        check({tv[i].name, " busy_fall"}, busy_fall_cyc, got_pcyc[got_pcyc.size()-1] + 1);
    end

    // FIFO full stall during the second push; a start while busy is ignored.
    load_table(1);
    start_run(32'h1000, st);
    for (int k = 0; k < 50 && got_push.size() < 1; k++) begin @(negedge clk); #3; end
    @(negedge clk); fifo_full_i = 1; start_i = 1; head_addr_i = 32'h5000;
    @(negedge clk); start_i = 0;
    repeat (7) @(negedge clk);
    fifo_full_i = 0;
    #3 rel = cyc;
    finish_run("stall");
    if (got_pcyc.size() > 1) check("stall second_push_at_release", got_pcyc[1], rel);

    // Delayed grant, then reset while stalled in PUSH.
    load_table(0);
    gnt_delay = 3; gnt_wait = 3; fifo_full_i = 1;
    start_run(32'h1000, st);
    repeat (15) @(negedge clk);
    #3;
    check("pre_reset busy_o", busy_o, 1);
    check("pre_reset req_addr", got_req.size() == 1 ? got_req[0] : 32'hFFFF_FFFF, 32'h1000);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    #3;
    check("post_reset busy_o", busy_o, 0);
    check("post_reset mem_req_o", mem_req_o, 0);
    check("post_reset mem_addr_o", mem_addr_o, 0);
    check("post_reset fifo_write_o", fifo_write_o, 0);
    check("post_reset fifo_data_o", fifo_data_o, 0);
    check("post_reset error_o", error_o, 0);
    check("post_reset err_addr_o", err_addr_o, 0);
    fifo_full_i = 0;
    repeat (10) @(negedge clk);
    #3;
    check("post_reset no_push", got_push.size(), 0);
    check("post_reset no_done", n_done, 0);

    // Reset while a read is in flight; the late rvalid must be ignored.
    gnt_delay = 0; gnt_wait = 0; rv_delay = 3;
    start_run(32'h1000, st);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    repeat (8) @(negedge clk);
    #3;
    check("inflight_reset busy_o", busy_o, 0);
    check("inflight_reset no_push", got_push.size(), 0);
    rv_delay = 0;

    start_run(32'h1000, st);
    finish_run("fresh_start");

    // Randomized chains against the reference model.
    rand_lat = 1; rand_full = 1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] base, nx, ln, head;
      int n;
      mem.delete();
      base = 32'h4000 + 32'(k) * 32'h100;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        nx = (i == n - 1) ? 32'h0 : base + 32'(16 * (i + 1));
        if (i == n - 1 && $urandom_range(0, 9) == 0) nx = base;
        if (nx != 0 && $urandom_range(0, 9) == 0) nx = nx | 32'h8;
        ln = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        mem[base + 32'(16 * i)] = mk($urandom, $urandom, ln, nx);
      end
      head = ($urandom_range(0, 9) == 0) ? base + 32'h4 : base;
      start_run(head, st);
      finish_run("random");
    end
    rand_full = 0; fifo_full_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000");
    $fatal(1);
  end

endmodule
